pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the address width of pc, target, stack data and return addresses.
REQ-002 Parameter RESET_VEC, default 0, SHALL be the pc value loaded on reset.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 clr  input  1  SHALL be the reset: asynchronous, active-low (clr=0 resets immediately, independent of clk).
REQ-005 run  input  1  SHALL qualify op; op is ignored when run=0.
REQ-006 op  input  3  SHALL be the opcode: 000 NOP, 001 INC, 010 JMP, 011 BRZ, 100 CALL, 101 RET, 110 HALT, 111 illegal.
REQ-007 target  input  WIDTH  SHALL be the destination for JMP, BRZ and CALL.
REQ-008 z  input  1  SHALL be the branch condition for BRZ.
REQ-009 stk_peek  input  WIDTH  SHALL be the top-of-stack value from the downstream stack.
REQ-010 stk_full, stk_not_empty  input  1 each  SHALL be the stack status flags.
REQ-011 pc  output  WIDTH  SHALL be the registered program counter.
REQ-012 stk_push  output  WIDTH  SHALL be the value to push (return address).
REQ-013 stk_en, stk_c  output  1 each  SHALL be the stack enable and control (c=1 push, c=0 pop).
REQ-014 busy  output  1  SHALL be 1 while a RET is in progress.
REQ-015 halted  output  1  SHALL be 1 in HALT state.
REQ-016 fault_code  output  2  SHALL report the halt cause: 00 none/HALT op, 01 overflow, 10 underflow, 11 illegal op.

Function
REQ-017 FSM states SHALL be RUN, RET_LOAD, HALT; RUN is the only state that accepts op.
REQ-018 stk_en, stk_c, stk_push SHALL be combinational from current state and inputs; pc, state, fault_code SHALL be registered.
REQ-019 In RUN with run=1: INC sets pc<=pc+1; NOP holds pc; JMP sets pc<=target; BRZ sets pc<=target if z=1 else pc+1.
REQ-020 CALL with stk_full=0 SHALL assert stk_en=1, stk_c=1, stk_push=pc+1 in the same cycle and set pc<=target (1-cycle latency).
REQ-021 CALL with stk_full=1 SHALL NOT assert stk_en, SHALL hold pc, and SHALL go to HALT with fault_code<=01.
REQ-022 RET with stk_not_empty=1 SHALL keep stk_en=0 that cycle (stack refreshes stk_peek) and go to RET_LOAD; pc holds.
REQ-023 RET_LOAD SHALL set pc<=stk_peek, assert stk_en=1, stk_c=0 (pop), and return to RUN; total RET latency 2 cycles.
REQ-024 RET with stk_not_empty=0 SHALL NOT touch the stack, hold pc, go to HALT with fault_code<=10.
REQ-025 op=110 SHALL go to HALT with fault_code<=00; op=111 SHALL go to HALT with fault_code<=11; pc holds in both.
REQ-026 busy SHALL be 1 exactly in RET_LOAD; op and run SHALL be ignored there.
REQ-027 HALT SHALL be exited only by reset; pc and fault_code hold, stk_en=0.
REQ-028 pc+1 SHALL wrap modulo 2^WIDTH (all-ones+1 = 0), including the CALL return address.
REQ-029 stk_en SHALL be 0 in every cycle and state not named in REQ-020/023.

Reset
REQ-030 clr=0 SHALL asynchronously force pc=RESET_VEC, state=RUN, fault_code=00; stk_en=0, stk_c=0, stk_push=0, busy=0, halted=0 while clr=0.
REQ-031 Reset asserted in RET_LOAD SHALL abort the RET with no pop issued after assertion.
REQ-032 After clr rises, the first rising edge SHALL accept op normally.

Verification
REQ-033 Reset, run=1, INC x3 -> pc 0,1,2,3; stk_en=0 throughout.
REQ-034 pc=0x10, CALL target=0x40 -> same cycle stk_en=1, stk_c=1, stk_push=0x11; next pc=0x40; then RET -> busy one cycle, pop in RET_LOAD, pc=0x11 two cycles after RET.
REQ-035 stk_full=1, CALL -> no stk_en, halted=1, fault_code=01, pc unchanged; further ops ignored until clr=0.
REQ-036 stk_not_empty=0, RET -> halted=1, fault_code=10; op=111 from reset -> fault_code=11.
REQ-037 WIDTH=8, pc=0xFF: INC -> pc=0x00; CALL -> stk_push=0x00; BRZ z=0 -> pc+1, z=1 -> target.
REQ-038 clr=0 pulsed mid-cycle during RET_LOAD -> pc=RESET_VEC immediately, busy=0, no pop on subsequent edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with call/return through an external stack.
// The stack handshake is combinational; pc, state and fault_code are registered.
module pc_sequencer #(
  parameter int                WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VEC = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] target,
  input  logic             z,
  input  logic [WIDTH-1:0] stk_peek,
  input  logic             stk_full,
  input  logic             stk_not_empty,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] stk_push,
  output logic             stk_en,
  output logic             stk_c,
  output logic             busy,
  output logic             halted,
  output logic [1:0]       fault_code
);

  // state    | meaning
  // RUN      | accepting op when run=1
  // RET_LOAD | second RET cycle: load pc from stk_peek and pop
  // HALT     | stopped until reset; fault_code holds the cause
  typedef enum logic [1:0] {S_RUN, S_RET_LOAD, S_HALT} state_t;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_INC  = 3'b001;
  localparam logic [2:0] OP_JMP  = 3'b010;
  localparam logic [2:0] OP_BRZ  = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b110;

  localparam logic [1:0] F_NONE  = 2'b00;
  localparam logic [1:0] F_OVF   = 2'b01;
  localparam logic [1:0] F_UNF   = 2'b10;
  localparam logic [1:0] F_ILL   = 2'b11;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pc_nxt;
  logic [WIDTH-1:0] pc_inc;
  logic [1:0]       fault_nxt;

  assign pc_inc = pc + ONE;
  assign busy   = (state == S_RET_LOAD);
  assign halted = (state == S_HALT);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state      <= S_RUN;
      pc         <= RESET_VEC;
      fault_code <= F_NONE;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      fault_code <= fault_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    fault_nxt = fault_code;
    stk_en    = 1'b0;
    stk_c     = 1'b0;
    stk_push  = pc_inc;
    unique case (state)
      S_RUN: begin
        if (run) begin
          unique case (op)
            OP_NOP: ;
            OP_INC: pc_nxt = pc_inc;
            OP_JMP: pc_nxt = target;
            OP_BRZ: pc_nxt = z ? target : pc_inc;
            OP_CALL: begin
              if (!stk_full) begin
                stk_en = 1'b1;
                stk_c  = 1'b1;
                pc_nxt = target;
              end else begin
                state_nxt = S_HALT;
                fault_nxt = F_OVF;
              end
            end
            // Pop is deferred to RET_LOAD so the stack has a cycle to present stk_peek.
            OP_RET: begin
              if (stk_not_empty) begin
                state_nxt = S_RET_LOAD;
              end else begin
                state_nxt = S_HALT;
                fault_nxt = F_UNF;
              end
            end
            OP_HALT: begin
              state_nxt = S_HALT;
              fault_nxt = F_NONE;
            end
            default: begin
              state_nxt = S_HALT;
              fault_nxt = F_ILL;
            end
          endcase
        end
      end
      S_RET_LOAD: begin
        pc_nxt    = stk_peek;
        stk_en    = 1'b1;
        stk_c     = 1'b0;
        state_nxt = S_RUN;
      end
      S_HALT: ;
      default: state_nxt = S_RUN;
    endcase
    // Keep the stack untouched for the whole time reset is held.
    if (!clr) begin
      stk_en   = 1'b0;
      stk_c    = 1'b0;
      stk_push = '0;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a vector table walked in order from reset,
// plus hand-written sequences for fault causes and reset during RET_LOAD.
module tb_pc_sequencer;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_INC  = 3'b001;
  localparam logic [2:0] OP_JMP  = 3'b010;
  localparam logic [2:0] OP_BRZ  = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  logic       clk = 1'b0;
  logic       clr;
  logic       run;
  logic [2:0] op;
  logic [7:0] target;
  logic       z;
  logic [7:0] stk_peek;
  logic       stk_full;
  logic       stk_not_empty;
  logic [7:0] pc;
  logic [7:0] stk_push;
  logic       stk_en;
  logic       stk_c;
  logic       busy;
  logic       halted;
  logic [1:0] fault_code;

  int checks = 0;
  int failures = 0;

  pc_sequencer #(.WIDTH(8), .RESET_VEC(8'h00)) dut (
    .clk(clk), .clr(clr), .run(run), .op(op), .target(target), .z(z),
    .stk_peek(stk_peek), .stk_full(stk_full), .stk_not_empty(stk_not_empty),
    .pc(pc), .stk_push(stk_push), .stk_en(stk_en), .stk_c(stk_c),
    .busy(busy), .halted(halted), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       run;
    logic [2:0] op;
    logic [7:0] target;
    logic       z;
    logic [7:0] peek;
    logic       full;
    logic       nempty;
    logic       en;      // stack outputs sampled before the edge
    logic       c;
    logic [7:0] push;
    logic [7:0] pc;      // registered results after the edge
    logic       busy;
    logic       halted;
    logic [1:0] fault;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [2:0] o, input logic [7:0] t, input logic zz,
                       input logic [7:0] pk, input logic fl, input logic ne);
    run = r; op = o; target = t; z = zz; stk_peek = pk; stk_full = fl; stk_not_empty = ne;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, OP_NOP, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    clr = 1'b0;
    #1;
    chk("rst_pc", 32'(pc), 32'h00);
    chk("rst_en", 32'(stk_en), 32'h0);
    chk("rst_push", 32'(stk_push), 32'h00);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_fault", 32'(fault_code), 32'h0);
    @(negedge clk);
    clr = 1'b1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    drive(v.run, v.op, v.target, v.z, v.peek, v.full, v.nempty);
    #1;
    chk($sformatf("v%0d_en", idx), 32'(stk_en), 32'(v.en));
    chk($sformatf("v%0d_c", idx), 32'(stk_c), 32'(v.c));
    chk($sformatf("v%0d_push", idx), 32'(stk_push), 32'(v.push));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_pc", idx), 32'(pc), 32'(v.pc));
    chk($sformatf("v%0d_busy", idx), 32'(busy), 32'(v.busy));
    chk($sformatf("v%0d_halted", idx), 32'(halted), 32'(v.halted));
    chk($sformatf("v%0d_fault", idx), 32'(fault_code), 32'(v.fault));
    @(negedge clk);
  endtask

  initial begin
    clr = 1'b1;
    drive(1'b0, OP_NOP, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

    //            run op       tgt    z  peek   fl ne  en c  push   pc     bsy hlt flt
    vq.push_back('{1, OP_INC,  8'h00, 0, 8'h00, 0, 0,  0, 0, 8'h01, 8'h01, 0,  0,  2'd0});
    vq.push_back('{1, OP_INC,  8'h00, 0, 8'h00, 0, 0,  0, 0, 8'h02, 8'h02, 0,  0,  2'd0});
    vq.push_back('{1, OP_INC,  8'h00, 0, 8'h00, 0, 0,  0, 0, 8'h03, 8'h03, 0,  0,  2'd0});
    vq.push_back('{1, OP_JMP,  8'h10, 0, 8'h00, 0, 0,  0, 0, 8'h04, 8'h10, 0,  0,  2'd0});
    vq.push_back('{1, OP_CALL, 8'h40, 0, 8'h00, 0, 0,  1, 1, 8'h11, 8'h40, 0,  0,  2'd0});
    vq.push_back('{1, OP_RET,  8'h00, 0, 8'h11, 0, 1,  0, 0, 8'h41, 8'h40, 1,  0,  2'd0});
    vq.push_back('{1, OP_JMP,  8'h99, 0, 8'h11, 0, 1,  1, 0, 8'h41, 8'h11, 0,  0,  2'd0});
    vq.push_back('{0, OP_INC,  8'h00, 0, 8'h00, 0, 0,  0, 0, 8'h12, 8'h11, 0,  0,  2'd0});
    vq.push_back('{1, OP_NOP,  8'h00, 0, 8'h00, 0, 0,  0, 0, 8'h12, 8'h11, 0,  0,  2'd0});
    vq.push_back('{1, OP_BRZ,  8'h80, 0, 8'h00, 0, 0,  0, 0, 8'h12, 8'h12, 0,  0,  2'd0});
    vq.push_back('{1, OP_BRZ,  8'h80, 1, 8'h00, 0, 0,  0, 0, 8'h13, 8'h80, 0,  0,  2'd0});
    vq.push_back('{1, OP_JMP,  8'hFE, 0, 8'h00, 0, 0,  0, 0, 8'h81, 8'hFE, 0,  0,  2'd0});
    vq.push_back('{1, OP_INC,  8'h00, 0, 8'h00, 0, 0,  0, 0, 8'hFF, 8'hFF, 0,  0,  2'd0});
    vq.push_back('{1, OP_CALL, 8'h20, 0, 8'h00, 0, 0,  1, 1, 8'h00, 8'h20, 0,  0,  2'd0});
    vq.push_back('{1, OP_JMP,  8'hFF, 0, 8'h00, 0, 0,  0, 0, 8'h21, 8'hFF, 0,  0,  2'd0});
    vq.push_back('{1, OP_BRZ,  8'h30, 0, 8'h00, 0, 0,  0, 0, 8'h00, 8'h00, 0,  0,  2'd0});
    vq.push_back('{1, OP_JMP,  8'hFF, 0, 8'h00, 0, 0,  0, 0, 8'h01, 8'hFF, 0,  0,  2'd0});
    vq.push_back('{1, OP_INC,  8'h00, 0, 8'h00, 0, 0,  0, 0, 8'h00, 8'h00, 0,  0,  2'd0});
    vq.push_back('{1, OP_CALL, 8'h55, 0, 8'h00, 1, 0,  0, 0, 8'h01, 8'h00, 0,  1,  2'd1});
    vq.push_back('{1, OP_INC,  8'h00, 0, 8'h00, 0, 0,  0, 0, 8'h01, 8'h00, 0,  1,  2'd1});
    vq.push_back('{1, OP_CALL, 8'h20, 0, 8'h00, 0, 0,  0, 0, 8'h01, 8'h00, 0,  1,  2'd1});
    vq.push_back('{1, OP_RET,  8'h00, 0, 8'h33, 0, 1,  0, 0, 8'h01, 8'h00, 0,  1,  2'd1});

    do_reset();
    foreach (vq[i]) apply(vq[i], i);

    // RET on an empty stack: underflow, no stack access
    do_reset();
    drive(1'b1, OP_RET, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    chk("unf_en", 32'(stk_en), 32'h0);
    @(posedge clk); #1;
    chk("unf_halted", 32'(halted), 32'h1);
    chk("unf_fault", 32'(fault_code), 32'h2);
    chk("unf_pc", 32'(pc), 32'h00);

    // Illegal op straight out of reset
    do_reset();
    drive(1'b1, OP_ILL, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("ill_halted", 32'(halted), 32'h1);
    chk("ill_fault", 32'(fault_code), 32'h3);

    // HALT op: clean stop
    do_reset();
    drive(1'b1, OP_INC, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, OP_HALT, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("hlt_halted", 32'(halted), 32'h1);
    chk("hlt_fault", 32'(fault_code), 32'h0);
    chk("hlt_pc", 32'(pc), 32'h01);

    // Reset pulsed in the middle of RET_LOAD aborts the pop
    do_reset();
    drive(1'b1, OP_JMP, 8'h22, 1'b0, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, OP_RET, 8'h00, 1'b0, 8'h77, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("abort_busy_pre", 32'(busy), 32'h1);
    chk("abort_en_pre", 32'(stk_en), 32'h1);
    chk("abort_pc_pre", 32'(pc), 32'h22);
    #2;
    clr = 1'b0;
    #1;
    chk("abort_pc", 32'(pc), 32'h00);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_en", 32'(stk_en), 32'h0);
    chk("abort_push", 32'(stk_push), 32'h00);
    @(posedge clk); #1;
    chk("abort_pc_edge", 32'(pc), 32'h00);
    chk("abort_en_edge", 32'(stk_en), 32'h0);
    @(negedge clk);
    clr = 1'b1;
    drive(1'b1, OP_INC, 8'h00, 1'b0, 8'h77, 1'b0, 1'b1);
    #1;
    chk("post_en", 32'(stk_en), 32'h0);
    chk("post_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;
    chk("post_pc", 32'(pc), 32'h01);
    chk("post_busy2", 32'(busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
